webfpga_button_events: RTL and testbench

// Consumes the clean level from the debouncer and turns it into single-cycle

---
 rtl/webfpga_button_events.sv | 127 ++++++++++++
 tb/tb_webfpga_button_events.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/webfpga_button_events.sv
// Turns a debounced button level into single-cycle press, release, long-press
// and auto-repeat strobes, plus a held flag and a wrapping press counter.
module webfpga_button_events #(
    parameter int unsigned LONG_CYCLES   = 12000000,
    parameter int unsigned REPEAT_CYCLES = 3000000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        S_ARM     = 2'd0,
        S_IDLE    = 2'd1,
        S_PRESSED = 2'd2,
        S_LONG    = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_e           state_q, state_d;
    logic             prev_level_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       count_q, count_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             rise, fall;

    assign rise = in_level & ~prev_level_q;
    assign fall = ~in_level & prev_level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_ARM;
            prev_level_q <= 1'b0;
            cnt_q        <= '0;
            count_q      <= 8'd0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_q       <= 1'b0;
            repeat_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_level_q <= in_level;
            cnt_q        <= cnt_d;
            count_q      <= count_d;
            press_q      <= press_d;
            release_q    <= release_d;
            long_q       <= long_d;
            repeat_q     <= repeat_d;
        end
    end

    // A release is checked before the timer so it wins a same-cycle collision.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        count_d   = count_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            S_ARM: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            S_IDLE: begin
                if (rise) begin
                    state_d = S_PRESSED;
                    press_d = 1'b1;
                    cnt_d   = '0;
                    count_d = count_q + 8'd1;
                end
            end
            S_PRESSED: begin
                if (fall) begin
                    state_d   = S_IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = S_LONG;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LONG: begin
                if (fall) begin
                    state_d   = S_IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_ARM;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        press_pulse   = press_q;
        release_pulse = release_q;
        long_pulse    = long_q;
        repeat_pulse  = repeat_q;
        held          = (state_q == S_PRESSED) || (state_q == S_LONG);
        press_count   = count_q;
    end

endmodule

// File: tb/tb_webfpga_button_events.sv
// Scenario bench for webfpga_button_events: expected strobes are queued from a
// timing model when stimulus is driven, observed strobes are queued by cycle.
module tb_webfpga_button_events;

    localparam int L   = 10;
    localparam int REP = 4;

    typedef struct {
        int         cyc;
        logic [3:0] kind;   // {press, release, long, repeat}
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_level = 1'b0;
    logic       press_pulse, release_pulse, long_pulse, repeat_pulse, held;
    logic [7:0] press_count;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   held_first, held_last, held_cnt, multi_cnt;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    webfpga_button_events #(
        .LONG_CYCLES  (L),
        .REPEAT_CYCLES(REP),
        .CNT_W        (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_level     (in_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    function automatic ev_t mk(input int c, input logic [3:0] k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        return e;
    endfunction

    // One clock cycle: drive inputs just after the edge, record outputs mid-cycle.
    task automatic step(input logic lvl, input logic rst);
        logic [3:0] k;
        @(posedge clk);
        #1;
        cyc++;
        in_level = lvl;
        reset    = rst;
        @(negedge clk);
        k = {press_pulse, release_pulse, long_pulse, repeat_pulse};
        if (k != 4'b0000) obs_q.push_back(mk(cyc, k));
        if ($countones(k) > 1) multi_cnt++;
        if (held) begin
            if (held_first < 0) held_first = cyc;
            held_last = cyc;
            held_cnt++;
        end
    endtask

    task automatic clear_logs();
        exp_q.delete();
        obs_q.delete();
        held_first = -1;
        held_last  = -1;
        held_cnt   = 0;
        multi_cnt  = 0;
    endtask

    task automatic do_reset(input logic lvl);
        step(lvl, 1'b1);
        step(lvl, 1'b1);
        step(lvl, 1'b0);
        step(lvl, 1'b0);
    endtask

    // Level high for relative cycles rise..rise+len-1 within a window of total cycles.
    task automatic drive_press(input int rise, input int len, input int total);
        int base, p, r, e;
        base = cyc;
        p = base + rise + 1;
        r = base + rise + len + 1;
        e = base + total;
        if (p <= e) exp_q.push_back(mk(p, 4'b1000));
        if (p + L < r && p + L <= e) exp_q.push_back(mk(p + L, 4'b0010));
        for (int t = p + L + REP; t < r && t <= e; t += REP)
            exp_q.push_back(mk(t, 4'b0001));
        if (r <= e) exp_q.push_back(mk(r, 4'b0100));
        for (int i = 1; i <= total; i++)
            step((i >= rise) && (i < rise + len), 1'b0);
    endtask

    task automatic test_reset();
        clear_logs();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {press_pulse, release_pulse, long_pulse, repeat_pulse, held});
        end
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", press_count);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        checks++;
        if (obs_q.size() != 0 || held_cnt != 0) begin
            errors++;
            $display("FAIL reset_quiet: got %0d strobes %0d held cycles expected 0 0",
                     obs_q.size(), held_cnt);
        end
    endtask

    task automatic test_short_press();
        ev_t e, o;
        int  base;
        clear_logs();
        do_reset(1'b0);
        base = cyc;
        drive_press(5, 3, 12);
        checks++;
        if (held_first != base + 6 || held_last != base + 8 || held_cnt != 3) begin
            errors++;
            $display("FAIL short_held: got first=%0d last=%0d n=%0d expected %0d %0d 3",
                     held_first - base, held_last - base, held_cnt, 6, 8);
        end
        checks++;
        if (press_count !== 8'd1) begin
            errors++;
            $display("FAIL short_count: got %0d expected 1", press_count);
        end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            checks++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); errors++;
                $display("FAIL short_sb: got strobe %b at %0d expected none", o.kind, o.cyc - base);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); errors++;
                $display("FAIL short_sb: got nothing expected %b at %0d", e.kind, e.cyc - base);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.cyc != e.cyc || o.kind !== e.kind) begin
                    errors++;
                    $display("FAIL short_sb: got %b at %0d expected %b at %0d",
                             o.kind, o.cyc - base, e.kind, e.cyc - base);
                end
            end
        end
    endtask

    task automatic test_long_repeat();
        ev_t e, o;
        int  base;
        clear_logs();
        do_reset(1'b0);
        base = cyc;
        drive_press(5, 25, 36);
        checks++;
        if (held_first != base + 6 || held_last != base + 30 || held_cnt != 25) begin
            errors++;
            $display("FAIL long_held: got first=%0d last=%0d n=%0d expected 6 30 25",
                     held_first - base, held_last - base, held_cnt);
        end
        checks++;
        if (multi_cnt != 0) begin
            errors++;
            $display("FAIL long_exclusive: got %0d multi-strobe cycles expected 0", multi_cnt);
        end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            checks++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); errors++;
                $display("FAIL long_sb: got strobe %b at %0d expected none", o.kind, o.cyc - base);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); errors++;
                $display("FAIL long_sb: got nothing expected %b at %0d", e.kind, e.cyc - base);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.cyc != e.cyc || o.kind !== e.kind) begin
                    errors++;
                    $display("FAIL long_sb: got %b at %0d expected %b at %0d",
                             o.kind, o.cyc - base, e.kind, e.cyc - base);
                end
            end
        end
    endtask

    task automatic test_held_through_reset();
        ev_t e, o;
        int  base;
        clear_logs();
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        base = cyc;
        drive_press(3, 4, 10);
        checks++;
        if (press_count !== 8'd1) begin
            errors++;
            $display("FAIL thru_reset_count: got %0d expected 1", press_count);
        end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            checks++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); errors++;
                $display("FAIL thru_reset_sb: got strobe %b at %0d expected none", o.kind, o.cyc - base);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); errors++;
                $display("FAIL thru_reset_sb: got nothing expected %b at %0d", e.kind, e.cyc - base);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.cyc != e.cyc || o.kind !== e.kind) begin
                    errors++;
                    $display("FAIL thru_reset_sb: got %b at %0d expected %b at %0d",
                             o.kind, o.cyc - base, e.kind, e.cyc - base);
                end
            end
        end
    endtask

    task automatic test_release_at_long();
        ev_t e, o;
        int  base;
        int  long_seen;
        clear_logs();
        do_reset(1'b0);
        base = cyc;
        drive_press(5, L, 20);
        long_seen = 0;
        foreach (obs_q[i]) if (obs_q[i].kind[1]) long_seen++;
        checks++;
        if (long_seen != 0) begin
            errors++;
            $display("FAIL collide_long: got %0d long strobes expected 0", long_seen);
        end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            checks++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); errors++;
                $display("FAIL collide_sb: got strobe %b at %0d expected none", o.kind, o.cyc - base);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); errors++;
                $display("FAIL collide_sb: got nothing expected %b at %0d", e.kind, e.cyc - base);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.cyc != e.cyc || o.kind !== e.kind) begin
                    errors++;
                    $display("FAIL collide_sb: got %b at %0d expected %b at %0d",
                             o.kind, o.cyc - base, e.kind, e.cyc - base);
                end
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        ev_t e, o;
        int  base;
        clear_logs();
        do_reset(1'b0);
        base = cyc;
        drive_press(5, 100, 17);
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b1;
        #1;
        checks++;
        if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== 5'b0
            || press_count !== 8'd0) begin
            errors++;
            $display("FAIL midhold_async: got %b count=%0d expected 00000 count=0",
                     {press_pulse, release_pulse, long_pulse, repeat_pulse, held}, press_count);
        end
        @(negedge clk);
        step(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL midhold_count: got %0d expected 0", press_count);
        end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            checks++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); errors++;
                $display("FAIL midhold_sb: got strobe %b at %0d expected none", o.kind, o.cyc - base);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); errors++;
                $display("FAIL midhold_sb: got nothing expected %b at %0d", e.kind, e.cyc - base);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.cyc != e.cyc || o.kind !== e.kind) begin
                    errors++;
                    $display("FAIL midhold_sb: got %b at %0d expected %b at %0d",
                             o.kind, o.cyc - base, e.kind, e.cyc - base);
                end
            end
        end
    endtask

    task automatic test_count_wrap();
        ev_t e, o;
        int  base;
        clear_logs();
        do_reset(1'b0);
        base = cyc;
        for (int n = 1; n <= 257; n++) begin
            drive_press(1, 1, 3);
            if (n == 128) begin
                checks++;
                if (press_count !== 8'd128) begin
                    errors++;
                    $display("FAIL wrap_mid: got %0d expected 128", press_count);
                end
            end
            if (n == 256) begin
                checks++;
                if (press_count !== 8'd0) begin
                    errors++;
                    $display("FAIL wrap_256: got %0d expected 0", press_count);
                end
            end
        end
        checks++;
        if (press_count !== 8'd1) begin
            errors++;
            $display("FAIL wrap_257: got %0d expected 1", press_count);
        end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            checks++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front(); errors++;
                $display("FAIL wrap_sb: got strobe %b at %0d expected none", o.kind, o.cyc - base);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front(); errors++;
                $display("FAIL wrap_sb: got nothing expected %b at %0d", e.kind, e.cyc - base);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.cyc != e.cyc || o.kind !== e.kind) begin
                    errors++;
                    $display("FAIL wrap_sb: got %b at %0d expected %b at %0d",
                             o.kind, o.cyc - base, e.kind, e.cyc - base);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_repeat();
        test_held_through_reset();
        test_release_at_long();
        test_reset_mid_hold();
        test_count_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
